// File: rtl/hci_core_mux_ooo_credit_pkg.sv
// Shared types and helpers for the credit-limited out-of-order HCI multiplexer.
package hci_mux_ooo_pkg;

  typedef enum logic [1:0] {ARB_RR, ARB_STARVE, ARB_FORCE} arb_mode_e;

  function automatic int unsigned chan_idx_w(input int unsigned nb_chan);
    return (nb_chan > 1) ? $clog2(nb_chan) : 1;
  endfunction

endpackage

// File: rtl/hci_core_mux_ooo_credit_tracker.sv
// Per-channel bookkeeping: outstanding credits, starvation age and optional statistics.
// Optional statistics counters are built when HCI_MUX_OOO_CREDIT_STATS_EN is defined.
module hci_core_mux_ooo_credit_tracker #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        eligible_i,
  input  logic        inc_i,
  input  logic        dec_i,
`ifdef HCI_MUX_OOO_CREDIT_STATS_EN
  input  logic        req_i,
  output logic [31:0] grant_cnt_o,
  output logic [31:0] stall_cnt_o,
`endif
  output logic        full_o,
  output logic        empty_o,
  output logic        underflow_o,
  output logic        starving_o
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [OW-1:0] outst_q, outst_d;
  logic [SW-1:0] starve_q, starve_d;

  assign full_o      = (outst_q >= OW'(MAX_OUTSTANDING));
  assign empty_o     = (outst_q == '0);
  assign underflow_o = dec_i & empty_o;
  assign starving_o  = (starve_q >= SW'(STARVE_LIMIT));

  always_comb begin
    outst_d = outst_q;
    if (inc_i && !dec_i) begin
      outst_d = outst_q + 1'b1;
    end else if (dec_i && !inc_i && !empty_o) begin
      outst_d = outst_q - 1'b1;
    end
    starve_d = starve_q;
    if (!eligible_i || inc_i) begin
      starve_d = '0;
    end else if (!starving_o) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst_q  <= '0;
      starve_q <= '0;
    end else if (clear_i) begin
      outst_q  <= '0;
      starve_q <= '0;
    end else begin
      outst_q  <= outst_d;
      starve_q <= starve_d;
    end
  end

`ifdef HCI_MUX_OOO_CREDIT_STATS_EN
  logic [31:0] grant_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (clear_i) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (inc_i) grant_cnt_q <= grant_cnt_q + 32'd1;
      if (req_i && !inc_i && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign grant_cnt_o = grant_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: rtl/hci_core_mux_ooo_credit.sv
// N-to-1 out-of-order HCI mux with per-channel credits, round-robin and starvation escalation.
// Define HCI_MUX_OOO_CREDIT_STATS_EN to add per-channel grant/stall counters.
module hci_core_mux_ooo_credit
  import hci_mux_ooo_pkg::*;
#(
  parameter int unsigned NB_CHAN         = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8,
  parameter int unsigned DW              = 32,
  parameter int unsigned AW              = 32,
  parameter int unsigned UW              = 1,
  parameter int unsigned IW              = 4,
  parameter int unsigned EW              = 1,
  parameter int unsigned EHW             = 0,
  localparam int unsigned CW             = chan_idx_w(NB_CHAN),
  localparam int unsigned OIW            = IW + CW,
  localparam int unsigned BW             = DW / 8,
  localparam int unsigned EHWP           = (EHW > 0) ? EHW : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                priority_force_i,
  input  logic [CW-1:0]       priority_i    [NB_CHAN],
  input  logic [NB_CHAN-1:0]  in_req_i,
  output logic [NB_CHAN-1:0]  in_gnt_o,
  input  logic [AW-1:0]       in_add_i      [NB_CHAN],
  input  logic [NB_CHAN-1:0]  in_wen_i,
  input  logic [DW-1:0]       in_data_i     [NB_CHAN],
  input  logic [BW-1:0]       in_be_i       [NB_CHAN],
  input  logic [UW-1:0]       in_user_i     [NB_CHAN],
  input  logic [IW-1:0]       in_id_i       [NB_CHAN],
  input  logic [EW-1:0]       in_ecc_i      [NB_CHAN],
  output logic [NB_CHAN-1:0]  in_r_valid_o,
  input  logic [NB_CHAN-1:0]  in_r_ready_i,
  output logic [DW-1:0]       in_r_data_o,
  output logic                in_r_opc_o,
  output logic [UW-1:0]       in_r_user_o,
  output logic [IW-1:0]       in_r_id_o,
  output logic [EW-1:0]       in_r_ecc_o,
  output logic [EHWP-1:0]     in_egnt_o     [NB_CHAN],
  output logic [EHWP-1:0]     in_r_evalid_o [NB_CHAN],
  output logic                out_req_o,
  input  logic                out_gnt_i,
  output logic [AW-1:0]       out_add_o,
  output logic                out_wen_o,
  output logic [DW-1:0]       out_data_o,
  output logic [BW-1:0]       out_be_o,
  output logic [UW-1:0]       out_user_o,
  output logic [OIW-1:0]      out_id_o,
  output logic [EW-1:0]       out_ecc_o,
  input  logic                out_r_valid_i,
  output logic                out_r_ready_o,
  input  logic [DW-1:0]       out_r_data_i,
  input  logic                out_r_opc_i,
  input  logic [UW-1:0]       out_r_user_i,
  input  logic [OIW-1:0]      out_r_id_i,
  input  logic [EW-1:0]       out_r_ecc_i,
  output logic [EHWP-1:0]     out_ereq_o,
  output logic [EHWP-1:0]     out_r_eready_o,
`ifdef HCI_MUX_OOO_CREDIT_STATS_EN
  output logic [31:0]         grant_cnt_o   [NB_CHAN],
  output logic [31:0]         stall_cnt_o   [NB_CHAN],
`endif
  output arb_mode_e           arb_mode_o,
  output logic                idle_o,
  output logic                err_o
);

  logic [NB_CHAN-1:0] full, empty, underflow, starving, eligible, dec_chan;
  logic [CW-1:0]      winner, best, rr_q, rr_d, r_chan;
  logic [CW:0]        sum, nxt;
  logic               found, r_chan_ok, drop, err_q;
  arb_mode_e          mode;

  assign eligible = in_req_i & ~full;

  always_comb begin
    winner = '0;
    best   = '0;
    found  = 1'b0;
    sum    = '0;
    mode   = ARB_RR;
    if (priority_force_i) begin
      mode = ARB_FORCE;
      for (int i = 0; i < NB_CHAN; i++) begin
        if (eligible[i] && (!found || (priority_i[i] < best))) begin
          found  = 1'b1;
          best   = priority_i[i];
          winner = CW'(i);
        end
      end
    end else if (|(eligible & starving)) begin
      mode = ARB_STARVE;
      for (int i = NB_CHAN - 1; i >= 0; i--) begin
        if (eligible[i] && starving[i]) winner = CW'(i);
      end
    end else begin
      // Descending scan so the closest eligible channel after rr_q is written last.
      for (int k = NB_CHAN - 1; k >= 0; k--) begin
        sum = {1'b0, rr_q} + (CW+1)'(k);
        if (sum >= (CW+1)'(NB_CHAN)) sum = sum - (CW+1)'(NB_CHAN);
        if (eligible[sum[CW-1:0]]) winner = sum[CW-1:0];
      end
    end
  end

  // Reset also forces the handshake signals low combinationally.
  assign out_req_o  = (|eligible) & ~rst_i;
  assign out_add_o  = in_add_i[winner];
  assign out_wen_o  = in_wen_i[winner];
  assign out_data_o = in_data_i[winner];
  assign out_be_o   = in_be_i[winner];
  assign out_user_o = in_user_i[winner];
  assign out_id_o   = {winner, in_id_i[winner]};
  assign out_ecc_o  = in_ecc_i[winner];
  assign arb_mode_o = mode;

  assign nxt  = {1'b0, winner} + 1'b1;
  assign rr_d = (out_req_o && out_gnt_i) ?
                ((nxt >= (CW+1)'(NB_CHAN)) ? '0 : nxt[CW-1:0]) : rr_q;

  assign r_chan    = out_r_id_i[OIW-1 -: CW];
  assign r_chan_ok = ({1'b0, r_chan} < (CW+1)'(NB_CHAN));
  assign drop      = out_r_valid_i & ~r_chan_ok;

  assign out_r_ready_o = r_chan_ok ? in_r_ready_i[r_chan] : 1'b1;
  assign in_r_data_o   = out_r_data_i;
  assign in_r_opc_o    = out_r_opc_i;
  assign in_r_user_o   = out_r_user_i;
  assign in_r_id_o     = out_r_id_i[IW-1:0];
  assign in_r_ecc_o    = out_r_ecc_i;

  always_comb begin
    in_gnt_o     = '0;
    in_r_valid_o = '0;
    dec_chan     = '0;
    for (int i = 0; i < NB_CHAN; i++) begin
      in_gnt_o[i]     = out_req_o & out_gnt_i & (winner == CW'(i));
      in_r_valid_o[i] = out_r_valid_i & ~rst_i & r_chan_ok & (r_chan == CW'(i));
      dec_chan[i]     = in_r_valid_o[i] & out_r_ready_o;
    end
  end

  for (genvar i = 0; i < NB_CHAN; i++) begin : g_trk
    hci_core_mux_ooo_credit_tracker #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .STARVE_LIMIT    (STARVE_LIMIT)
    ) u_tracker (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (clear_i),
      .eligible_i  (eligible[i]),
      .inc_i       (in_gnt_o[i]),
      .dec_i       (dec_chan[i]),
`ifdef HCI_MUX_OOO_CREDIT_STATS_EN
      .req_i       (in_req_i[i]),
      .grant_cnt_o (grant_cnt_o[i]),
      .stall_cnt_o (stall_cnt_o[i]),
`endif
      .full_o      (full[i]),
      .empty_o     (empty[i]),
      .underflow_o (underflow[i]),
      .starving_o  (starving[i])
    );
  end

  if (EHW > 0) begin : g_ecc
    for (genvar i = 0; i < NB_CHAN; i++) begin : g_ch
      assign in_egnt_o[i]     = {EHWP{in_gnt_o[i]}};
      assign in_r_evalid_o[i] = {EHWP{in_r_valid_o[i]}};
    end
    assign out_ereq_o     = {EHWP{out_req_o}};
    assign out_r_eready_o = {EHWP{out_r_ready_o}};
  end else begin : g_no_ecc
    for (genvar i = 0; i < NB_CHAN; i++) begin : g_ch
      assign in_egnt_o[i]     = '1;
      assign in_r_evalid_o[i] = '0;
    end
    assign out_ereq_o     = '0;
    assign out_r_eready_o = '1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q  <= '0;
      err_q <= 1'b0;
    end else if (clear_i) begin
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      err_q <= err_q | drop | (|underflow);
    end
  end

  assign idle_o = &empty;
  assign err_o  = err_q;

endmodule

// File: tb/tb_hci_core_mux_ooo_credit.sv
// Directed bench for hci_core_mux_ooo_credit with grant and response scoreboards.
module tb_hci_core_mux_ooo_credit;
  import hci_mux_ooo_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, clear_i, priority_force_i;
  logic [1:0]  priority_i [4];
  logic [3:0]  in_req_i, in_gnt_o, in_wen_i, in_r_valid_o, in_r_ready_i;
  logic [31:0] in_add_i [4];
  logic [31:0] in_data_i [4];
  logic [3:0]  in_be_i [4];
  logic [0:0]  in_user_i [4];
  logic [3:0]  in_id_i [4];
  logic [0:0]  in_ecc_i [4];
  logic [31:0] in_r_data_o;
  logic        in_r_opc_o;
  logic [0:0]  in_r_user_o;
  logic [3:0]  in_r_id_o;
  logic [0:0]  in_r_ecc_o;
  logic [0:0]  in_egnt_o [4];
  logic [0:0]  in_r_evalid_o [4];
  logic        out_req_o, out_gnt_i, out_wen_o, out_r_valid_i, out_r_ready_o, out_r_opc_i;
  logic [31:0] out_add_o, out_data_o, out_r_data_i;
  logic [3:0]  out_be_o;
  logic [0:0]  out_user_o, out_ecc_o, out_r_user_i, out_r_ecc_i, out_ereq_o, out_r_eready_o;
  logic [5:0]  out_id_o, out_r_id_i;
  arb_mode_e   arb_mode_o;
  logic        idle_o, err_o;
`ifdef HCI_MUX_OOO_CREDIT_STATS_EN
  logic [31:0] grant_cnt_o [4];
  logic [31:0] stall_cnt_o [4];
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int gq[$];
  int rq_ch[$];
  logic [3:0] rq_id[$];

  always #5 clk_i = ~clk_i;

  hci_core_mux_ooo_credit dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .clear_i          (clear_i),
    .priority_force_i (priority_force_i),
    .priority_i       (priority_i),
    .in_req_i         (in_req_i),
    .in_gnt_o         (in_gnt_o),
    .in_add_i         (in_add_i),
    .in_wen_i         (in_wen_i),
    .in_data_i        (in_data_i),
    .in_be_i          (in_be_i),
    .in_user_i        (in_user_i),
    .in_id_i          (in_id_i),
    .in_ecc_i         (in_ecc_i),
    .in_r_valid_o     (in_r_valid_o),
    .in_r_ready_i     (in_r_ready_i),
    .in_r_data_o      (in_r_data_o),
    .in_r_opc_o       (in_r_opc_o),
    .in_r_user_o      (in_r_user_o),
    .in_r_id_o        (in_r_id_o),
    .in_r_ecc_o       (in_r_ecc_o),
    .in_egnt_o        (in_egnt_o),
    .in_r_evalid_o    (in_r_evalid_o),
    .out_req_o        (out_req_o),
    .out_gnt_i        (out_gnt_i),
    .out_add_o        (out_add_o),
    .out_wen_o        (out_wen_o),
    .out_data_o       (out_data_o),
    .out_be_o         (out_be_o),
    .out_user_o       (out_user_o),
    .out_id_o         (out_id_o),
    .out_ecc_o        (out_ecc_o),
    .out_r_valid_i    (out_r_valid_i),
    .out_r_ready_o    (out_r_ready_o),
    .out_r_data_i     (out_r_data_i),
    .out_r_opc_i      (out_r_opc_i),
    .out_r_user_i     (out_r_user_i),
    .out_r_id_i       (out_r_id_i),
    .out_r_ecc_i      (out_r_ecc_i),
    .out_ereq_o       (out_ereq_o),
    .out_r_eready_o   (out_r_eready_o),
`ifdef HCI_MUX_OOO_CREDIT_STATS_EN
    .grant_cnt_o      (grant_cnt_o),
    .stall_cnt_o      (stall_cnt_o),
`endif
    .arb_mode_o       (arb_mode_o),
    .idle_o           (idle_o),
    .err_o            (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_clear();
    in_req_i         = '0;
    out_gnt_i        = 1'b0;
    out_r_valid_i    = 1'b0;
    priority_force_i = 1'b0;
    clear_i          = 1'b1;
    tick();
    clear_i          = 1'b0;
  endtask

  // Consume the expected grant order; a stalled queue within the budget is a failure.
  task automatic run_grants(input int budget);
    for (int c = 0; c < budget && gq.size() > 0; c++) begin
      #1;
      if (out_req_o && out_gnt_i) begin
        int e = gq.pop_front();
        chk("grant_onehot", in_gnt_o, 4'b0001 << e);
        chk("grant_out_id", out_id_o, {e[1:0], in_id_i[e]});
      end
      tick();
    end
    chk("grant_queue_drained", gq.size(), 0);
  endtask

  task automatic check_resp();
    int         ch;
    logic [3:0] id;
    if (rq_ch.size() == 0) begin
      chk("resp_queue_nonempty", 0, 1);
    end else begin
      ch = rq_ch.pop_front();
      id = rq_id.pop_front();
      chk("resp_r_valid", in_r_valid_o, 4'b0001 << ch);
      chk("resp_r_id", in_r_id_o, id);
      chk("resp_r_ready", out_r_ready_o, 1);
    end
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; priority_force_i = 1'b0;
    in_req_i = '0; in_wen_i = '0; in_r_ready_i = '0;
    out_gnt_i = 1'b0; out_r_valid_i = 1'b0; out_r_id_i = '0;
    out_r_data_i = 32'hdead_beef; out_r_opc_i = 1'b0; out_r_user_i = '0; out_r_ecc_i = '0;
    for (int i = 0; i < 4; i++) begin
      priority_i[i] = '0;
      in_add_i[i]   = 32'h1000 * i;
      in_data_i[i]  = 32'hA0 + i;
      in_be_i[i]    = 4'hF;
      in_user_i[i]  = '0;
      in_id_i[i]    = 4'(i + 5);
      in_ecc_i[i]   = '0;
    end
    #1;
    chk("reset_idle", idle_o, 1);
    chk("reset_err", err_o, 0);
    chk("reset_gnt", in_gnt_o, 0);
    chk("reset_r_valid", in_r_valid_o, 0);
    repeat (2) tick();
    rst_i = 1'b0;

    // All channels busy, no responses: round-robin until every credit is spent.
    in_req_i  = 4'hF;
    out_gnt_i = 1'b1;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) gq.push_back(c);
    run_grants(24);
    #1;
    chk("all_full_req", out_req_o, 0);
    chk("all_full_gnt", in_gnt_o, 0);
    chk("all_full_idle", idle_o, 0);
    do_clear();
    #1;
    chk("clear_idle", idle_o, 1);

    // Single ch0 transaction, response first back-pressured then accepted.
    in_req_i  = 4'b0001;
    out_gnt_i = 1'b1;
    rq_ch.push_back(0);
    rq_id.push_back(4'd5);
    #1;
    chk("ch0_gnt", in_gnt_o, 4'b0001);
    chk("ch0_out_id", out_id_o, 6'h05);
    tick();
    in_req_i = '0;
    #1;
    chk("ch0_pending_idle", idle_o, 0);
    out_r_valid_i = 1'b1;
    out_r_id_i    = 6'h05;
    in_r_ready_i  = 4'b0000;
    #1;
    chk("bp_r_ready", out_r_ready_o, 0);
    chk("bp_r_valid", in_r_valid_o, 4'b0001);
    tick();
    #1;
    chk("bp_keeps_credit", idle_o, 0);
    in_r_ready_i = 4'b0001;
    #1;
    check_resp();
    tick();
    out_r_valid_i = 1'b0;
    #1;
    chk("ch0_done_idle", idle_o, 1);
    chk("ch0_done_err", err_o, 0);

    // Response for ch1 with no credit outstanding.
    out_r_valid_i = 1'b1;
    out_r_id_i    = 6'h10;
    in_r_ready_i  = 4'hF;
    #1;
    chk("orphan_r_valid", in_r_valid_o, 4'b0010);
    tick();
    out_r_valid_i = 1'b0;
    #1;
    chk("orphan_err", err_o, 1);
    chk("orphan_idle", idle_o, 1);
    tick();
    #1;
    chk("orphan_err_sticky", err_o, 1);
    do_clear();
    #1;
    chk("clear_err", err_o, 0);

    // ch2 at the limit: same-cycle response does not free the credit until the next cycle.
    in_req_i  = 4'b0100;
    out_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) gq.push_back(2);
    run_grants(8);
    #1;
    chk("ch2_limit_gnt", in_gnt_o, 0);
    chk("ch2_limit_req", out_req_o, 0);
    out_r_valid_i = 1'b1;
    out_r_id_i    = 6'h27;
    in_r_ready_i  = 4'b0100;
    #1;
    chk("ch2_same_cycle_gnt", in_gnt_o, 0);
    chk("ch2_same_cycle_rvalid", in_r_valid_o, 4'b0100);
    tick();
    out_r_valid_i = 1'b0;
    #1;
    chk("ch2_regranted", in_gnt_o, 4'b0100);
    tick();
    #1;
    chk("ch2_full_again", in_gnt_o, 0);
    do_clear();

    // ch3 ages without a handshake; ch0 arrives and loses once ch3 hits the limit.
    in_req_i  = 4'b1000;
    out_gnt_i = 1'b0;
    repeat (7) tick();
    in_req_i = 4'b1001;
    #1;
    chk("pre_starve_winner", out_id_o[5:4], 0);
    chk("pre_starve_mode", arb_mode_o, ARB_RR);
    tick();
    #1;
    chk("starve_winner", out_id_o[5:4], 3);
    chk("starve_mode", arb_mode_o, ARB_STARVE);
    out_gnt_i = 1'b1;
    #1;
    chk("starve_gnt", in_gnt_o, 4'b1000);
    tick();
    #1;
    chk("rr_after_starve", in_gnt_o, 4'b0001);
    do_clear();

    // Forced priorities: ch3 highest until out of credits, then ch2.
    priority_force_i = 1'b1;
    priority_i[0] = 2'd3; priority_i[1] = 2'd2; priority_i[2] = 2'd1; priority_i[3] = 2'd0;
    in_req_i  = 4'hF;
    out_gnt_i = 1'b1;
    #1;
    chk("force_mode", arb_mode_o, ARB_FORCE);
    gq.push_back(3); gq.push_back(3); gq.push_back(3); gq.push_back(3); gq.push_back(2);
    run_grants(10);

    // Asynchronous reset with credits outstanding and traffic on both paths.
    priority_force_i = 1'b0;
    out_r_valid_i    = 1'b1;
    out_r_id_i       = 6'h30;
    in_r_ready_i     = 4'hF;
    #1;
    chk("pre_reset_r_valid", in_r_valid_o, 4'b1000);
    chk("pre_reset_idle", idle_o, 0);
    rst_i = 1'b1;
    #1;
    chk("async_reset_gnt", in_gnt_o, 0);
    chk("async_reset_r_valid", in_r_valid_o, 0);
    chk("async_reset_idle", idle_o, 1);
    chk("async_reset_err", err_o, 0);
    tick();
    rst_i         = 1'b0;
    out_r_valid_i = 1'b0;
    in_req_i      = '0;
    #1;
    chk("post_reset_idle", idle_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not finish");
  end

endmodule
